// File: rtl/gray_ptr_pkg.sv
// gray_ptr_pkg: pointer sizing and Gray/binary helpers for the Gray pointer synchroniser.
package gray_ptr_pkg;
   function automatic int ptr_width(input int addr_w);
      return addr_w + 1;
   endfunction
   function automatic int ptr_depth(input int addr_w);
      return 1 << addr_w;
   endfunction
   localparam int ADDR_W = 4;
   localparam int PW     = ptr_width(ADDR_W);
   localparam int DEPTH  = ptr_depth(ADDR_W);
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/Gray2Binary.sv
// Gray2Binary: combinational Gray-to-binary converter.
module Gray2Binary #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign o_bin[i] = ^i_gray[WIDTH-1:i];
   end
endmodule

// File: rtl/gray_sync_chain.sv
// gray_sync_chain: bare multi-flop synchroniser, isolated so CDC constraints can target it.
module gray_sync_chain #(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
   end
   assign o_sync = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: brings a foreign-domain Gray pointer into clk, converts it to binary,
// computes occupancy against the local pointer and flags illegal pointer steps.
module gray_ptr_sync
   import gray_ptr_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ADDR_W:0] gray_ptr_async,
   input  logic [ADDR_W:0] local_ptr_bin,
   output logic [ADDR_W:0] ptr_gray_sync,
   output logic [ADDR_W:0] ptr_bin_sync,
   output logic [ADDR_W:0] level,
   output logic            empty,
   output logic            sync_valid,
   output logic            step_err,
   output logic            err_sticky
);
   localparam int            PW_L    = ptr_width(ADDR_W);
   localparam logic [PW_L-1:0] DEPTH_P = PW_L'(ptr_depth(ADDR_W));

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("gray_ptr_sync: SYNC_STAGES must be 2..4");
   end

   logic [PW_L-1:0] w_gray_s, w_bin_next, w_level_next, w_delta;
   logic            w_step_bad, w_level_bad;
   logic [2:0]      r_cnt;

   gray_sync_chain #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(PW_L)) u_sync (
      .clk(clk), .rst_n(rst_n), .i_async(gray_ptr_async), .o_sync(w_gray_s)
   );

   Gray2Binary #(.WIDTH(PW_L)) u_g2b (.i_gray(w_gray_s), .o_bin(w_bin_next));

   // Backward moves wrap to large deltas, so one unsigned compare covers both error cases.
   assign w_level_next = w_bin_next - local_ptr_bin;
   assign w_delta      = w_bin_next - ptr_bin_sync;
   assign w_step_bad   = sync_valid && (w_delta > DEPTH_P);
   assign w_level_bad  = sync_valid && (w_level_next > DEPTH_P);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_gray_sync <= '0;
         ptr_bin_sync  <= '0;
         level         <= '0;
         empty         <= 1'b1;
         sync_valid    <= 1'b0;
         step_err      <= 1'b0;
         err_sticky    <= 1'b0;
         r_cnt         <= '0;
      end else begin
         ptr_gray_sync <= w_gray_s;
         ptr_bin_sync  <= w_bin_next;
         level         <= w_level_next;
         empty         <= (w_bin_next == local_ptr_bin);
         step_err      <= w_step_bad;
         err_sticky    <= err_sticky | w_step_bad | w_level_bad;
         if (!sync_valid) begin
            r_cnt      <= r_cnt + 3'd1;
            sync_valid <= (r_cnt == 3'(SYNC_STAGES));
         end
      end
   end
endmodule

// File: tb/tb_gray_ptr_sync.sv
// tb_gray_ptr_sync: directed checks of sync latency, occupancy, wrap, step errors and reset.
module tb_gray_ptr_sync;
   import gray_ptr_pkg::*;

   logic       clk, rst_n;
   logic [4:0] gray_ptr_async, local_ptr_bin;
   logic [4:0] ptr_gray_sync, ptr_bin_sync, level;
   logic       empty, sync_valid, step_err, err_sticky;
   int         n_cmp = 0;
   int         n_err = 0;

   gray_ptr_sync #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .gray_ptr_async(gray_ptr_async), .local_ptr_bin(local_ptr_bin),
      .ptr_gray_sync(ptr_gray_sync), .ptr_bin_sync(ptr_bin_sync), .level(level), .empty(empty),
      .sync_valid(sync_valid), .step_err(step_err), .err_sticky(err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int b);
      gray_ptr_async = 5'(bin2gray(32'(b)));
   endtask

   task automatic do_reset(input int src, input int loc);
      @(negedge clk);
      rst_n = 1'b0;
      set_src(src);
      local_ptr_bin = 5'(loc);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      gray_ptr_async = 5'($urandom);
      local_ptr_bin = '0;
      #22;
      chk("rst_gray", ptr_gray_sync, 0);
      chk("rst_bin", ptr_bin_sync, 0);
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_valid", sync_valid, 0);
      chk("rst_step", step_err, 0);
      chk("rst_sticky", err_sticky, 0);
      // basic: gray 00111 = bin 5 lands on the 3rd edge after release
      gray_ptr_async = 5'b00111;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("e1_valid", sync_valid, 0);
      tick();
      chk("e2_valid", sync_valid, 0);
      chk("e2_bin", ptr_bin_sync, 0);
      tick();
      chk("e3_valid", sync_valid, 1);
      chk("e3_bin", ptr_bin_sync, 5);
      chk("e3_gray", ptr_gray_sync, 5'b00111);
      chk("e3_level", level, 5);
      chk("e3_empty", empty, 0);
      local_ptr_bin = 5'd5;
      tick();
      chk("loc5_empty", empty, 1);
      chk("loc5_level", level, 0);
      // legal walk up to 30 keeping level within depth
      set_src(20);
      repeat (4) tick();
      chk("s20_level", level, 15);
      local_ptr_bin = 5'd20;
      tick();
      chk("l20_level", level, 0);
      set_src(30);
      repeat (4) tick();
      chk("s30_level", level, 10);
      local_ptr_bin = 5'd30;
      tick();
      chk("w30_level", level, 0);
      chk("w30_empty", empty, 1);
      gray_ptr_async = 5'b10000;
      repeat (4) tick();
      chk("w31_level", level, 1);
      chk("w31_empty", empty, 0);
      chk("w31_step", step_err, 0);
      gray_ptr_async = 5'b00000;
      repeat (4) tick();
      chk("w0_bin", ptr_bin_sync, 0);
      chk("w0_level", level, 2);
      chk("w0_empty", empty, 0);
      gray_ptr_async = 5'b00001;
      repeat (4) tick();
      chk("w1_level", level, 3);
      chk("w1_step", step_err, 0);
      chk("wrap_sticky", err_sticky, 0);
      // illegal forward jump 2 -> 20 (delta 18)
      gray_ptr_async = 5'b00011;
      repeat (4) tick();
      chk("j2_level", level, 4);
      chk("j2_sticky", err_sticky, 0);
      gray_ptr_async = 5'b11110;
      tick();
      tick();
      chk("j_pre_step", step_err, 0);
      tick();
      chk("j_bin", ptr_bin_sync, 20);
      chk("j_step", step_err, 1);
      tick();
      chk("j_post_step", step_err, 0);
      chk("j_sticky", err_sticky, 1);
      tick();
      chk("j_sticky_hold", err_sticky, 1);
      // backward step 10 -> 9 (delta 31)
      do_reset(10, 10);
      chk("b_bin", ptr_bin_sync, 10);
      chk("b_sticky_clr", err_sticky, 0);
      set_src(9);
      tick();
      tick();
      chk("b_pre_step", step_err, 0);
      tick();
      chk("b_step", step_err, 1);
      tick();
      chk("b_post_step", step_err, 0);
      chk("b_sticky", err_sticky, 1);
      // level exactly depth is legal, one more overflows without a step error
      do_reset(0, 0);
      chk("o_sticky_clr", err_sticky, 0);
      set_src(16);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("o16_step", step_err, 0);
      end
      chk("o16_level", level, 16);
      chk("o16_sticky", err_sticky, 0);
      set_src(17);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("o17_step", step_err, 0);
      end
      chk("o17_level", level, 17);
      chk("o17_sticky", err_sticky, 1);
      // reset mid-run while at 12
      do_reset(0, 0);
      set_src(12);
      repeat (4) tick();
      chk("m_bin", ptr_bin_sync, 12);
      chk("m_level", level, 12);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("m_rst_bin", ptr_bin_sync, 0);
      chk("m_rst_gray", ptr_gray_sync, 0);
      chk("m_rst_level", level, 0);
      chk("m_rst_empty", empty, 1);
      chk("m_rst_valid", sync_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("m_e1_valid", sync_valid, 0);
      tick();
      chk("m_e2_bin", ptr_bin_sync, 0);
      tick();
      chk("m_e3_bin", ptr_bin_sync, 12);
      chk("m_e3_valid", sync_valid, 1);
      chk("m_e3_step", step_err, 0);
      tick();
      chk("m_e4_step", step_err, 0);
      chk("m_e4_sticky", err_sticky, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/gray_ptr_sync.md
Name: gray_ptr_sync

Overview:
- Receive-side stage for a Gray-coded pointer generated in a foreign clock domain, e.g. the async-FIFO write pointer arriving in the read domain.
- Synchronises the pointer into the local clock, converts it to binary, and computes occupancy against the local binary pointer.
- Flags illegal pointer steps.
- Sits directly downstream of the remote binary-to-Gray encoder and directly feeds the local full/empty and flow-control logic.

Parameters:
- ADDR_W, 4, FIFO address width. Pointer width PW = ADDR_W+1; DEPTH = 2**ADDR_W.
- SYNC_STAGES, 2, synchroniser flop count. Legal values are 2..4; elaboration error outside that range.

Ports:
- clk  in  1  local clock.
- rst_n  in  1  asynchronous active-low reset; release is synchronous to clk.
- gray_ptr_async  in  PW  Gray pointer from the foreign domain; asynchronous to clk.
- local_ptr_bin  in  PW  local binary pointer, synchronous to clk.
- ptr_gray_sync  out  PW  synchronised Gray pointer, registered.
- ptr_bin_sync  out  PW  synchronised pointer converted to binary, registered.
- level  out  PW  (ptr_bin_sync - local_ptr_bin) mod 2**PW, registered.
- empty  out  1  ptr_bin_sync == local_ptr_bin, registered.
- sync_valid  out  1  outputs are meaningful after reset.
- step_err  out  1  one-cycle pulse on an illegal pointer step.
- err_sticky  out  1  set by step_err or level overflow; cleared only by reset.

Behaviour:
- Reset (rst_n low, asynchronous): every sync flop and every output goes to 0, except empty, which goes to 1.
- Sync chain:
  - SYNC_STAGES flops on gray_ptr_async; g_s is the last stage.
  - No logic between stages.
- Conversion:
  - bin_next = gray-to-binary(g_s), combinational.
  - Each cycle, registers ptr_gray_sync <= g_s and ptr_bin_sync <= bin_next.
- Latency: a stable gray_ptr_async change appears on ptr_bin_sync SYNC_STAGES+1 rising edges later.
- Level and empty: on the same edge, level <= bin_next - local_ptr_bin (PW-bit wrap arithmetic) and empty <= (bin_next == local_ptr_bin). local_ptr_bin is sampled at that edge.
- Step check:
  - delta = bin_next - ptr_bin_sync, mod 2**PW.
  - delta in 0..DEPTH is legal; multi-count jumps within DEPTH are allowed because the source clock may be faster.
  - delta > DEPTH (over-advance or backward move, since backward wraps to a large value) makes step_err = 1 for exactly that cycle and sets err_sticky.
- Level overflow: level > DEPTH sets err_sticky only; step_err does not pulse.
- Start-up:
  - sync_valid is driven by a saturating counter from reset and rises on the (SYNC_STAGES+1)-th rising edge after rst_n release.
  - step_err and err_sticky updates are suppressed while sync_valid = 0.
- Wrap-around: the pointer passing 2**PW-1 -> 0 is a legal delta of 1; level stays correct across the wrap.
- Simultaneous events: a step error and a level overflow in the same cycle produce one step_err pulse; err_sticky is simply set.
- Reset mid-operation: outputs return to reset values immediately, without waiting for clk; sync_valid restarts its count on release.
- No handshake: the block is free-running and updates every clk.

Decomposition:
- Package gray_ptr_pkg:
  - localparams PW and DEPTH as functions of ADDR_W.
  - functions bin2gray and gray2bin, for benches and models.
- Sub-modules:
  - gray_sync_chain (SYNC_STAGES, WIDTH): the bare flop chain, kept separate so CDC tooling can be constrained on it.
  - The conversion instantiates the existing Gray2Binary library module with WIDTH = PW.

Test Plan (ADDR_W=4, SYNC_STAGES=2):
- Reset: hold rst_n low with random gray_ptr_async -> all outputs 0 and empty=1; after release, sync_valid=1 on the 3rd edge.
- Basic: gray_ptr_async=5'b00111 (bin 5), local_ptr_bin=0 -> on the 3rd edge, ptr_bin_sync=5, ptr_gray_sync=00111, level=5, empty=0. Then local_ptr_bin=5 -> empty=1 and level=0 on the next edge.
- Wrap: with local_ptr_bin=30, step the source 30, 31, 0, 1 (gray 10001, 10000, 00000, 00001), one value every 4 clocks -> level goes 0, 1, 2, 3; empty is 1 only at 30; step_err is never asserted.
- Illegal jump: source goes 2 (00011) -> 20 (11110) -> step_err is a single-cycle pulse on the edge where ptr_bin_sync becomes 20 (delta 18 > 16); err_sticky=1 and is held.
- Backward step: source goes 10 -> 9 -> delta=31, step_err pulses, err_sticky=1. Level overflow: local_ptr_bin=0 with source 17 reached via legal steps -> err_sticky=1, no step_err.
- Reset mid-run: at ptr_bin_sync=12, drop rst_n between edges -> outputs clear asynchronously and empty=1. After release with source still 12 -> ptr_bin_sync=12 after 3 edges, no step_err because the check is suppressed until sync_valid.
